// File: rtl/pool2d_if.sv
// rtl/pool2d_if.sv - frame interface bundle for the pool2d pooling layer
interface pool2d_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_SIZE    = 28,
    parameter int POOL       = 2,
    parameter int STRIDE     = 2
);
    localparam int OUT_SIZE = (IN_SIZE - POOL) / STRIDE + 1;

    logic                         start;
    logic                         mode;
    logic signed [DATA_WIDTH-1:0] in_feature  [CHANNELS][IN_SIZE][IN_SIZE];
    logic signed [DATA_WIDTH-1:0] out_feature [CHANNELS][OUT_SIZE][OUT_SIZE];
    logic                         busy;
    logic                         done;

    // Upstream side: issues start/mode and supplies the input maps.
    modport master (
        output start, mode, in_feature,
        input  out_feature, busy, done
    );

    // Pooling layer side.
    modport slave (
        input  start, mode, in_feature,
        output out_feature, busy, done
    );
endinterface

// File: rtl/pool2d.sv
// rtl/pool2d.sv - 2-D max/average pooling, one window element per cycle
module pool2d #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_SIZE    = 28,
    parameter int POOL       = 2,
    parameter int STRIDE     = 2
) (
    input  logic     clk,
    input  logic     reset,
    pool2d_if.slave  p
);
    localparam int OUT_SIZE = (IN_SIZE - POOL) / STRIDE + 1;
    localparam int SHIFT    = 2 * $clog2(POOL);
    localparam int ACC_W    = DATA_WIDTH + SHIFT;

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int IW = $clog2(IN_SIZE);
    localparam int PW = $clog2(POOL);

    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_SIZE - 1);
    localparam logic [PW-1:0] P_LAST = PW'(POOL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

    state_t                   state;
    logic                     busy_q;
    logic                     done_q;
    logic                     mode_q;
    logic [CW-1:0]            ch;
    logic [OW-1:0]            r;
    logic [OW-1:0]            q;
    logic [PW-1:0]            wr;
    logic [PW-1:0]            wc;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_WIDTH-1:0] out_q [CHANNELS][OUT_SIZE][OUT_SIZE];

    logic [IW-1:0]               row;
    logic [IW-1:0]               col;
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [ACC_W-1:0]      x_ext;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      max_v;
    logic signed [DATA_WIDTH-1:0] fin;
    logic                         first;
    logic                         last;

    // Element address within the current window and its sign-extended value.
    assign row   = IW'(r) * IW'(STRIDE) + IW'(wr);
    assign col   = IW'(q) * IW'(STRIDE) + IW'(wc);
    assign x     = p.in_feature[ch][row][col];
    assign x_ext = {{SHIFT{x[DATA_WIDTH-1]}}, x};

    // Fold candidates: running sum and signed running maximum.
    assign sum   = acc + x_ext;
    assign max_v = (x_ext > acc) ? x_ext : acc;

    assign first = (wr == '0) && (wc == '0);
    assign last  = (wr == P_LAST) && (wc == P_LAST);

    // Final window value; the arithmetic shift floors the average, and
    // the average always fits back into DATA_WIDTH.
    assign fin = DATA_WIDTH'(mode_q ? (sum >>> SHIFT) : max_v);

    // Control FSM, window counters, accumulator and output map registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mode_q <= 1'b0;
            ch     <= '0;
            r      <= '0;
            q      <= '0;
            wr     <= '0;
            wc     <= '0;
            acc    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int y = 0; y < OUT_SIZE; y++) begin
                    for (int z = 0; z < OUT_SIZE; z++) begin
                        out_q[c][y][z] <= '0;
                    end
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (p.start) begin
                        mode_q <= p.mode;
                        ch     <= '0;
                        r      <= '0;
                        q      <= '0;
                        wr     <= '0;
                        wc     <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (first) begin
                        acc <= x_ext;
                    end else if (mode_q) begin
                        acc <= sum;
                    end else begin
                        acc <= max_v;
                    end

                    if (last) begin
                        out_q[ch][r][q] <= fin;
                    end

                    // wc fastest, then wr, q, r, ch.
                    if (wc != P_LAST) begin
                        wc <= wc + PW'(1);
                    end else begin
                        wc <= '0;
                        if (wr != P_LAST) begin
                            wr <= wr + PW'(1);
                        end else begin
                            wr <= '0;
                            if (q != O_LAST) begin
                                q <= q + OW'(1);
                            end else begin
                                q <= '0;
                                if (r != O_LAST) begin
                                    r <= r + OW'(1);
                                end else begin
                                    r <= '0;
                                    if (ch != C_LAST) begin
                                        ch <= ch + CW'(1);
                                    end else begin
                                        ch    <= '0;
                                        state <= FINISH;
                                    end
                                end
                            end
                        end
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign p.busy        = busy_q;
    assign p.done        = done_q;
    assign p.out_feature = out_q;
endmodule

// File: tb/tb_pool2d.sv
// tb/tb_pool2d.sv - scoreboard bench for pool2d (2x2/2 and 2x2/1 configurations)
module tb_pool2d;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clk = ~clk;

    pool2d_if #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(2)) a_if ();
    pool2d_if #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(1)) b_if ();

    pool2d #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(2)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .p     (a_if.slave)
    );

    pool2d #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(1)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .p     (b_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int qa[$];
    int qb[$];

    // Windows indexed by c*4 + r*2 + q, elements by wr*2 + wc.
    int win [8][4] = '{
        '{-5, 3, 7, -1},
        '{-8, -3, -9, -4},
        '{32767, -32768, 5, 1},
        '{-32768, -32768, -32768, -32768},
        '{1, 2, 3, 5},
        '{-1, -2, -3, -5},
        '{32767, 32767, 32767, 32767},
        '{10, -20, 30, -40}
    };
    int exp_max [8] = '{7, -3, 32767, -32768, 5, -1, 32767, 30};
    int exp_avg [8] = '{1, -6, 1, -32768, 2, -3, 32767, -5};

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the stride-2 instance.
    always @(negedge clk) begin
        if (a_if.done) begin
            for (int c = 0; c < 2; c++) begin
                for (int r = 0; r < 2; r++) begin
                    for (int q = 0; q < 2; q++) begin
                        if (qa.size() == 0) begin
                            check("a_unexpected_done", 1, 0);
                        end else begin
                            check($sformatf("a_out[%0d][%0d][%0d]", c, r, q),
                                  int'(a_if.out_feature[c][r][q]), qa.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Scoreboard monitor for the stride-1 instance.
    always @(negedge clk) begin
        if (b_if.done) begin
            for (int c = 0; c < 2; c++) begin
                for (int r = 0; r < 3; r++) begin
                    for (int q = 0; q < 3; q++) begin
                        if (qb.size() == 0) begin
                            check("b_unexpected_done", 1, 0);
                        end else begin
                            check($sformatf("b_out[%0d][%0d][%0d]", c, r, q),
                                  int'(b_if.out_feature[c][r][q]), qb.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic push_a(input bit avg);
        for (int i = 0; i < 8; i++) begin
            qa.push_back(avg ? exp_avg[i] : exp_max[i]);
        end
    endtask

    // One pass on instance A with optional mode toggle at E0+5 and a stray start at E0+10.
    task automatic run_a(input bit md, input bit toggle, input bit extra, input string tag);
        int busy_cnt;
        int done_edge;
        int done_cnt;
        a_if.mode  = md;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        busy_cnt  = a_if.busy ? 1 : 0;
        done_edge = -1;
        done_cnt  = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (toggle && k == 5) a_if.mode = ~md;
            if (extra && k == 10) a_if.start = 1'b1;
            if (extra && k == 11) a_if.start = 1'b0;
            if (a_if.busy) busy_cnt++;
            if (a_if.done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
            end
        end
        check({tag, "_done_edge"}, done_edge, 33);
        check({tag, "_done_cycles"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, 33);
    endtask

    initial begin
        int d1;
        int d2;
        int b_busy;
        int b_done;
        int a_done;

        reset_a = 1'b1;
        reset_b = 1'b1;
        a_if.start = 1'b0;
        a_if.mode  = 1'b0;
        b_if.start = 1'b0;
        b_if.mode  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 2; r++) begin
                for (int q = 0; q < 2; q++) begin
                    for (int e = 0; e < 4; e++) begin
                        a_if.in_feature[c][2*r + e/2][2*q + e%2] = 16'(win[c*4 + r*2 + q][e]);
                    end
                end
            end
            for (int y = 0; y < 4; y++) begin
                for (int x = 0; x < 4; x++) begin
                    b_if.in_feature[c][y][x] = 16'(4*y + x);
                end
            end
        end
        tick();
        tick();

        check("reset_busy", int'(a_if.busy), 0);
        check("reset_done", int'(a_if.done), 0);
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 2; r++)
                for (int q = 0; q < 2; q++)
                    check("reset_out", int'(a_if.out_feature[c][r][q]), 0);

        reset_a = 1'b0;
        reset_b = 1'b0;
        tick();

        // Max mode, with a mode toggle and an ignored start mid-pass.
        push_a(1'b0);
        run_a(1'b0, 1'b1, 1'b1, "max");

        // Average mode, including floor and no-overflow windows.
        push_a(1'b1);
        run_a(1'b1, 1'b0, 1'b0, "avg");

        // Back-to-back passes with start held high.
        push_a(1'b0);
        push_a(1'b0);
        a_if.mode  = 1'b0;
        a_if.start = 1'b1;
        tick();
        d1 = -1;
        d2 = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (a_if.done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (d1 >= 0 && k == d1 + 1) a_if.start = 1'b0;
        end
        a_if.start = 1'b0;
        check("b2b_first_done", d1, 33);
        check("b2b_period", d2 - d1, 34);

        // Reset in the middle of an average pass.
        a_if.mode  = 1'b1;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        #2 reset_a = 1'b1;
        #1;
        check("rst_busy", int'(a_if.busy), 0);
        check("rst_done", int'(a_if.done), 0);
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 2; r++)
                for (int q = 0; q < 2; q++)
                    check("rst_out", int'(a_if.out_feature[c][r][q]), 0);
        tick();
        reset_a = 1'b0;
        a_done = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (a_if.done) a_done++;
        end
        check("rst_no_done", a_done, 0);

        push_a(1'b0);
        run_a(1'b0, 1'b0, 1'b0, "post_rst");

        // Overlapping stride on instance B: ramp input, max mode.
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 3; r++)
                for (int q = 0; q < 3; q++)
                    qb.push_back(4*(r + 1) + q + 1);
        b_if.mode  = 1'b0;
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        b_busy = b_if.busy ? 1 : 0;
        b_done = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (b_if.busy) b_busy++;
            if (b_if.done && b_done < 0) b_done = k;
        end
        check("s1_busy_cycles", b_busy, 73);
        check("s1_done_edge", b_done, 73);

        tick();
        check("a_sb_left", qa.size(), 0);
        check("b_sb_left", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/pool2d.md
# pool2d

Parametrised 2-D pooling layer. It succeeds the fixed 2×2 max-pool stage and supports a configurable window, configurable stride, and a run-time max/average mode. The block sits between a conv stage and the next layer on the same array-in/array-out frame interface. It visits one window element per cycle, so datapath cost stays flat as POOL grows, and it pulses `done` after each full pass over all channels.

## Interface
- DATA_WIDTH, 16, bits per signed element
- CHANNELS, 8, feature-map channels
- IN_SIZE, 28, input map height/width
- POOL, 2, window height/width; must be a power of two ≥ 2 (required by average mode)
- STRIDE, 2, window step; 1 ≤ STRIDE ≤ POOL
- Derived: OUT_SIZE = (IN_SIZE−POOL)/STRIDE + 1; SHIFT = 2·log2(POOL); ACC_W = DATA_WIDTH + SHIFT
- Clocking (already decided): one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one pass; sampled only in IDLE
- mode  in  1  0 = max, 1 = average; latched when start is accepted
- in_feature  in  signed DATA_WIDTH × [CHANNELS][IN_SIZE][IN_SIZE]  input maps; must be held stable while busy
- out_feature  out  signed DATA_WIDTH × [CHANNELS][OUT_SIZE][OUT_SIZE]  pooled maps
- busy  out  1  a pass is in progress
- done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: done←0. If start: mode_q←mode, ch←r←q←wr←wc←0, busy←1, go to SCAN.
  - SCAN: each cycle, read x = in_feature[ch][r·STRIDE+wr][q·STRIDE+wc].
    - First element of the window (wr=wc=0): acc←x (sign-extended).
    - Other elements: max mode acc←max(acc,x) with signed compare; average mode acc←acc+x.
    - Last element (wr=wc=POOL−1): write the final value directly to out_feature[ch][r][q], folding x into the result in the same cycle. Max mode writes max(acc,x). Average mode writes (acc+x)>>>SHIFT, which is arithmetic and floors toward −∞, truncated to DATA_WIDTH (no overflow is possible).
  - Counter order: wc fastest, then wr, then q, then r, then ch. After the last element of the last window of the last channel, go to FINISH.
  - FINISH: done←1, busy←0, go to IDLE.
- Accumulator width is ACC_W, signed; it never saturates.
- out_feature entries keep their last written value between passes. Entries are overwritten only by a pass.
- start is ignored while busy. mode changes after acceptance have no effect on the current pass.
- A start held high through FINISH is accepted in the following IDLE cycle. That is the same edge that clears done, so passes run back-to-back.
- Reset at any time forces:
  - state IDLE, busy 0, done 0, all counters 0, acc 0
  - every out_feature entry to 0
  - the pass in progress is abandoned with no done pulse.

## Timing
- Reset values: busy=0, done=0, out_feature all 0.
- Let E0 be the edge that accepts start, and N = CHANNELS·OUT_SIZE²·POOL².
- SCAN occupies edges E0+1 … E0+N. out_feature[ch][r][q] updates at the edge that consumes that window's last element.
- FINISH is active at edge E0+N+1: done rises and busy falls.
- done is high for exactly one cycle, from E0+N+1 to E0+N+2.
- busy is high for exactly N+1 cycles.
- Start-to-done latency is N+1 cycles. Back-to-back pass period is N+2 cycles.

## Test plan
- **Max mode.** CHANNELS=2, IN_SIZE=4, POOL=2, STRIDE=2. Input windows {−5,3,7,−1} and {−8,−3,−9,−4} → outputs 7 and −3. Mixed-sign and all-negative cases are both checked.
- **Average mode.** Same parameters. Windows {1,2,3,5} → 2; {−1,−2,−3,−5} → −3 (floor). Window of four 32767 values → 32767 (accumulator does not overflow).
- **Overlapping stride.** POOL=2, STRIDE=1, IN_SIZE=4, max mode. Ramp input in[c][y][x] = 4y+x → out[c][r][q] = 4(r+1)+q+1 over a 3×3 output; busy lasts 2·9·4+1 = 73 cycles.
- **Latency and handshake.** Default 2×2/2 configuration with CHANNELS=2, IN_SIZE=4 (N=32):
  - done is high exactly at E0+33 for one cycle; busy is high for 33 cycles.
  - A start pulse at E0+10 is ignored.
  - Toggling mode at E0+5 does not change the results.
- **Back-to-back.** start held high continuously → done pulses every 34 cycles, and the second pass's results match the first.
- **Reset mid-pass.** Assert reset at E0+10:
  - busy=0, done=0, and all out_feature entries are 0, asynchronously before the next clock edge.
  - No done pulse appears.
  - A subsequent start completes with correct outputs.
